// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, owner tags, default widths.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

endpackage

// File: rtl/dmem_fair_picker.sv
// Winner select between pipeline and loader. The pipeline normally wins ties; after
// STARVE_LIMIT consecutive pipeline grants with the loader waiting, the loader is forced in.
module dmem_fair_picker
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   idle,
  input  logic   pipe_req,
  input  logic   ldr_req,
  output owner_e winner
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_ldr;

  // Combinational grant: loader wins when alone or when it has been starved long enough.
  always_comb begin
    force_ldr = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    winner    = OWN_PIPE;
    if (ldr_req && (!pipe_req || force_ldr)) begin
      winner = OWN_LDR;
    end
  end

  // Starvation counter: only evaluated in IDLE, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!ldr_req || (winner == OWN_LDR)) begin
        starve_cnt <= '0;
      end else if (pipe_req && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the MEM stage and the loader port.
// Each access: IDLE sample -> ISSUE (mem_en pulse) -> WAIT (read latency) -> DONE (ack) -> IDLE.
// The ack cycle is the DONE state, so a request still high during ack is not re-sampled;
// the following IDLE cycle is the bubble in which the next command is sampled.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_ack,
  output logic              pipe_err,
  output logic              pipe_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              ldr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_e        state;
  owner_e            owner;
  owner_e            winner;
  logic              cmd_we;
  logic              cmd_err;
  logic [CNT_W-1:0]  cnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] resp_data;

  dmem_fair_picker #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_picker (
    .clk      (clk),
    .rst      (rst),
    .idle     (state == S_IDLE),
    .pipe_req (pipe_req),
    .ldr_req  (ldr_req),
    .winner   (winner)
  );

  // Command mux from the winning requester, and the response word returned at ack.
  always_comb begin
    sel_we    = pipe_we;
    sel_addr  = pipe_addr;
    sel_wdata = pipe_wdata;
    if (winner == OWN_LDR) begin
      sel_we    = ldr_we;
      sel_addr  = ldr_addr;
      sel_wdata = ldr_wdata;
    end
    resp_data = (cmd_we || cmd_err) ? '0 : mem_rdata;
  end

  // Stall is combinational so the MEM stage releases in the same cycle as the ack.
  assign pipe_stall = pipe_req & ~pipe_ack & ~rst;

  // Access sequencer: owns state, latency counter, memory strobes and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_PIPE;
      cmd_we     <= 1'b0;
      cmd_err    <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pipe_rdata <= '0;
      pipe_ack   <= 1'b0;
      pipe_err   <= 1'b0;
      ldr_rdata  <= '0;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
    end else begin
      // Responses are single-cycle; they are cleared everywhere except on DONE entry.
      mem_en     <= 1'b0;
      pipe_ack   <= 1'b0;
      pipe_err   <= 1'b0;
      pipe_rdata <= '0;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
      ldr_rdata  <= '0;
      case (state)
        S_IDLE: begin
          if (pipe_req || ldr_req) begin
            owner  <= winner;
            cmd_we <= sel_we;
            if (sel_addr[1:0] != 2'b00) begin
              // Misaligned: spend one cycle in WAIT so the ack lands one cycle after sampling.
              cmd_err <= 1'b1;
              cnt     <= '0;
              state   <= S_WAIT;
            end else begin
              cmd_err   <= 1'b0;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr[ADDR_W-1:2];
              mem_wdata <= sel_wdata;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_DONE;
            if (owner == OWN_LDR) begin
              ldr_ack   <= 1'b1;
              ldr_err   <= cmd_err;
              ldr_rdata <= resp_data;
            end else begin
              pipe_ack   <= 1'b1;
              pipe_err   <= cmd_err;
              pipe_rdata <= resp_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a latency-accurate memory model.
module tb_dmem_port_arbiter;

  localparam int LAT = 3;
  localparam int SL  = 2;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_req = 1'b0, pipe_we = 1'b0;
  logic [31:0] pipe_addr = '0, pipe_wdata = '0;
  logic [31:0] pipe_rdata;
  logic        pipe_ack, pipe_err, pipe_stall;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic [31:0] ldr_rdata;
  logic        ldr_ack, ldr_err;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe [0:LAT-1];

  int   cyc = 0;
  int   en_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q [$];

  dmem_port_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (32),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_req   (pipe_req),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_ack   (pipe_ack),
    .pipe_err   (pipe_err),
    .pipe_stall (pipe_stall),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_rdata  (ldr_rdata),
    .ldr_ack    (ldr_ack),
    .ldr_err    (ldr_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the index of the preceding posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on strobe, read data emerges LAT cycles after the strobe cycle.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[5:0]] : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever either port acks.
  always @(negedge clk) begin
    exp_t e;
    if (mem_en) en_cnt++;
    if (!rst && (pipe_ack || ldr_ack)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: pipe_ack=%b ldr_ack=%b expected none", pipe_ack, ldr_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_port", {31'b0, ldr_ack}, {31'b0, e.port});
        chk("ack_rdata", ldr_ack ? ldr_rdata : pipe_rdata, e.rdata);
        chk("ack_err", {31'b0, ldr_ack ? ldr_err : pipe_err}, {31'b0, e.err});
        chk("other_quiet", {31'b0, ldr_ack ? (pipe_ack | pipe_err | (|pipe_rdata))
                                           : (ldr_ack | ldr_err | (|ldr_rdata))}, 32'd0);
      end
    end
  end

  // One complete access on a port: latency, stall shape and strobe count checked here,
  // data/err checked by the monitor.
  task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input string tag);
    int   s, en0, lat;
    logic got, stall_ok;
    @(posedge clk); #1;
    if (!port) begin
      pipe_we = we; pipe_addr = addr; pipe_wdata = wd; pipe_req = 1'b1;
    end else begin
      ldr_we = we; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
    end
    exp_q.push_back({port, exp_rd, exp_err});
    s = cyc + 1; en0 = en_cnt; got = 1'b0; stall_ok = 1'b1; lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (port ? ldr_ack : pipe_ack) begin
        got = 1'b1;
        lat = cyc - s;
        if (!port && pipe_stall !== 1'b0) stall_ok = 1'b0;
      end else if (!port && pipe_stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    chk({tag, "_latency"}, lat, exp_err ? 32'd1 : LAT + 1);
    if (!port) chk({tag, "_stall"}, {31'b0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    if (!port) pipe_req = 1'b0; else ldr_req = 1'b0;
    chk({tag, "_mem_en_count"}, en_cnt - en0, exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_ack, n_en;
    int   en_cyc [$];
    logic gap_ok;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pipe_out", {29'b0, pipe_ack, pipe_err, pipe_stall}, 32'd0);
    chk("rst_ldr_out", {30'b0, ldr_ack, ldr_err}, 32'd0);
    chk("rst_mem_out", {30'b0, mem_en, mem_we}, 32'd0);
    chk("rst_rdata", pipe_rdata | ldr_rdata | mem_wdata, 32'd0);
    rst = 1'b0;

    // Loader store then pipeline load of the same word
    do_access(1'b1, 1'b1, 32'h0, 32'h000000AA, 32'h0, 1'b0, "t1_ldr_sw");
    do_access(1'b0, 1'b0, 32'h0, 32'h0, 32'h000000AA, 1'b0, "t1_pipe_lw");

    // Pipeline store/load round trip
    do_access(1'b0, 1'b1, 32'h8, 32'h12345678, 32'h0, 1'b0, "t2_pipe_sw");
    do_access(1'b0, 1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, "t2_pipe_lw");

    // Misaligned accesses on both ports
    do_access(1'b0, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, "t4_pipe_mis");
    do_access(1'b1, 1'b1, 32'h5, 32'hFFFFFFFF, 32'h0, 1'b1, "t4_ldr_mis");

    // Preload words for the contention run
    do_access(1'b1, 1'b1, 32'h10, 32'h00000011, 32'h0, 1'b0, "t3_pre_l");
    do_access(1'b1, 1'b1, 32'h14, 32'h00000022, 32'h0, 1'b0, "t3_pre_p");

    // Both ports held high: grant order P,P,L,P,P,L and strobes spaced LAT+3 apart
    @(posedge clk); #1;
    pipe_we = 1'b0; pipe_addr = 32'h14; pipe_req = 1'b1;
    ldr_we  = 1'b0; ldr_addr  = 32'h10; ldr_req  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2 || k == 5) exp_q.push_back({1'b1, 32'h00000011, 1'b0});
      else                  exp_q.push_back({1'b0, 32'h00000022, 1'b0});
    end
    n_ack = 0;
    for (int i = 0; i < 200 && n_ack < 6; i++) begin
      @(negedge clk);
      if (mem_en) en_cyc.push_back(cyc);
      if (pipe_ack || ldr_ack) n_ack++;
    end
    @(posedge clk); #1;
    pipe_req = 1'b0; ldr_req = 1'b0;
    chk("t3_ack_count", n_ack, 32'd6);
    chk("t3_strobe_count", en_cyc.size(), 32'd6);
    gap_ok = 1'b1;
    for (int i = 1; i < en_cyc.size(); i++)
      if (en_cyc[i] - en_cyc[i-1] != LAT + 3) gap_ok = 1'b0;
    chk("t6_strobe_spacing", {31'b0, gap_ok}, 32'd1);

    // Reset in the middle of WAIT abandons the access
    @(posedge clk); #1;
    pipe_we = 1'b0; pipe_addr = 32'h8; pipe_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("t5_rst_acks", {30'b0, pipe_ack, ldr_ack}, 32'd0);
    chk("t5_rst_stall", {31'b0, pipe_stall}, 32'd0);
    pipe_req = 1'b0;
    n_en = en_cnt;
    n_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (pipe_ack || ldr_ack) n_ack++;
    end
    chk("t5_no_ack_in_rst", n_ack, 32'd0);
    chk("t5_no_strobe_in_rst", en_cnt - n_en, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_access(1'b0, 1'b0, 32'h8, 32'h0, 32'h12345678, 1'b0, "t5_after_rst");

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
